// File: rtl/float_to_lin.sv
// Converts an 11-bit float word {sign, exp[3:0], mant[5:0]} into a 16-bit
// sign-magnitude linear value, shifting the mantissa left one bit per cycle.
module float_to_lin (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] dq0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] dq,
  output logic        fmt_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [20:0] acc_reg, acc_next;
  logic [20:0] acc_shl;
  logic [3:0]  cnt_reg, cnt_next;
  logic        sign_reg, sign_next;
  logic        err_reg, err_next;
  logic [15:0] dq_reg, dq_next;
  logic        fmt_err_reg, fmt_err_next;

  logic        in_sign;
  logic [3:0]  in_exp;
  logic [5:0]  in_mant;
  logic        in_err;

  assign in_sign = dq0[10];
  assign in_exp  = dq0[9:6];
  assign in_mant = dq0[5:0];
  // A non-zero exponent with a clear leading mantissa bit is not normalized.
  assign in_err  = (in_exp != 4'd0) && !in_mant[5];

  // Accumulator shifted left by one; 21 bits hold 63 << 15 without loss.
  genvar gi;
  assign acc_shl[0] = 1'b0;
  generate
    for (gi = 1; gi < 21; gi++) begin : g_shl
      assign acc_shl[gi] = acc_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      sign_reg    <= 1'b0;
      err_reg     <= 1'b0;
      dq_reg      <= '0;
      fmt_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      sign_reg    <= sign_next;
      err_reg     <= err_next;
      dq_reg      <= dq_next;
      fmt_err_reg <= fmt_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    sign_next    = sign_reg;
    err_next     = err_reg;
    dq_next      = dq_reg;
    fmt_err_next = fmt_err_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          acc_next   = {15'd0, in_mant};
          cnt_next   = in_exp;
          sign_next  = in_sign;
          err_next   = in_err;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg != 4'd0) begin
          acc_next = acc_shl;
          cnt_next = cnt_reg - 4'd1;
        end else begin
          // The final >>6 is just the choice of output bit slice.
          dq_next      = {sign_reg, acc_reg[20:6]};
          fmt_err_next = err_reg;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign dq        = dq_reg;
  assign fmt_err   = fmt_err_reg;

endmodule

// File: tb/tb_float_to_lin.sv
// Scoreboard bench for float_to_lin: expected results are queued when a word
// is accepted and popped when the converter presents its result.
module tb_float_to_lin;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] dq0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dq;
  logic        fmt_err;

  typedef struct {
    logic [15:0] dq;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  float_to_lin dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dq0       (dq0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dq        (dq),
    .fmt_err   (fmt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [10:0] w);
    exp_t r;
    int   mag;
    mag   = {26'd0, w[5:0]};
    mag   = (mag << w[9:6]) >> 6;
    r.dq  = {w[10], mag[14:0]};
    r.err = (w[9:6] != 4'd0) && !w[5];
    r.lat = int'(w[9:6]) + 1;
    return r;
  endfunction

  // Called at a negedge: offers the word, it is accepted on the next posedge,
  // and returns at the following negedge with in_valid dropped.
  task automatic apply(input logic [10:0] w);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL apply_in_ready word=%h got=%b want=1", w, in_ready);
    end
    in_valid = 1'b1;
    dq0      = w;
    sb.push_back(model(w));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid; no comparison here.
  task automatic collect(output int lat, output bit timeout);
    lat     = 0;
    timeout = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) timeout = 1'b1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dq0       = '0;
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (dq !== 16'h0000 || fmt_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values got dq=%h err=%b ov=%b ir=%b want dq=0000 err=0 ov=0 ir=1",
               dq, fmt_err, out_valid, in_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [10:0] words[4];
    exp_t        e;
    int          lat;
    bit          to;
    words     = '{11'h020, 11'h7FF, 11'h1E8, 11'h0D0};
    out_ready = 1'b1;
    foreach (words[i]) begin
      apply(words[i]);
      collect(lat, to);
      e = sb.pop_front();
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL vec_timeout word=%h no out_valid within 40 edges", words[i]);
      end
      vectors++;
      if (dq !== e.dq || fmt_err !== e.err || lat !== e.lat) begin
        miscompares++;
        $display("FAIL vec_result word=%h got dq=%h err=%b lat=%0d want dq=%h err=%b lat=%0d",
                 words[i], dq, fmt_err, lat, e.dq, e.err, e.lat);
      end
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL vec_release word=%h got ir=%b ov=%b want ir=1 ov=0",
                 words[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int   lat;
    bit   to;
    out_ready = 1'b1;
    apply(11'h7FF);
    in_valid = 1'b1;
    dq0      = 11'h0D0;
    repeat (4) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_in_ready got=%b want=0", in_ready);
    end
    in_valid = 1'b0;
    collect(lat, to);
    lat = lat + 4;
    e = sb.pop_front();
    vectors++;
    if (to || dq !== e.dq || fmt_err !== e.err || lat !== e.lat) begin
      miscompares++;
      $display("FAIL busy_result got dq=%h err=%b lat=%0d to=%b want dq=%h err=%b lat=%0d",
               dq, fmt_err, lat, to, e.dq, e.err, e.lat);
    end
    @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_no_queue got ov=%b want=0", out_valid);
    end
  endtask

  task automatic test_hold;
    exp_t e;
    int   lat;
    bit   to;
    out_ready = 1'b0;
    apply(11'h1E8);
    collect(lat, to);
    e = sb.pop_front();
    vectors++;
    if (to || dq !== e.dq || lat !== e.lat) begin
      miscompares++;
      $display("FAIL hold_first got dq=%h lat=%0d to=%b want dq=%h lat=%0d",
               dq, lat, to, e.dq, e.lat);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2);
      dq0      = 11'h7FF;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || dq !== e.dq || fmt_err !== e.err || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d got ov=%b dq=%h err=%b ir=%b want ov=1 dq=%h err=%b ir=0",
                 c, out_valid, dq, fmt_err, in_ready, e.dq, e.err);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dq !== e.dq) begin
      miscompares++;
      $display("FAIL hold_release got ir=%b ov=%b dq=%h want ir=1 ov=0 dq=%h",
               in_ready, out_valid, dq, e.dq);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_no_queue got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   lat;
    bit   to;
    out_ready = 1'b1;
    apply(11'h7FF);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    void'(sb.pop_back());
    vectors++;
    if (dq !== 16'h0000 || fmt_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_values got dq=%h err=%b ov=%b ir=%b want dq=0000 err=0 ov=0 ir=1",
               dq, fmt_err, out_valid, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL midreset_hold%0d got ov=%b ir=%b want ov=0 ir=1", c, out_valid, in_ready);
      end
    end
    reset_n = 1'b1;
    apply(11'h1E8);
    collect(lat, to);
    e = sb.pop_front();
    vectors++;
    if (to || dq !== 16'h0050 || dq !== e.dq || fmt_err !== e.err || lat !== e.lat) begin
      miscompares++;
      $display("FAIL midreset_next got dq=%h err=%b lat=%0d to=%b want dq=%h err=%b lat=%0d",
               dq, fmt_err, lat, to, e.dq, e.err, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    int          lat;
    bit          to;
    logic [10:0] w;
    out_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      w = 11'($urandom_range(0, 2047));
      if (n == 0) w = 11'h7C0;
      if (n == 1) w = 11'h03F;
      apply(w);
      collect(lat, to);
      e = sb.pop_front();
      vectors++;
      if (to || dq !== e.dq || fmt_err !== e.err || lat !== e.lat) begin
        miscompares++;
        $display("FAIL b2b_%0d word=%h got dq=%h err=%b lat=%0d to=%b want dq=%h err=%b lat=%0d",
                 n, w, dq, fmt_err, lat, to, e.dq, e.err, e.lat);
      end
      @(negedge clk);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_vectors;
    test_busy_ignore;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/float_to_lin.md
FLOAT_TO_LIN -- requirements
Module: float_to_lin

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 11-bit float format: sign bit 10, exponent bits 9:6, mantissa bits 5:0.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 IN_VALID  input  1  DQ0 holds a float word to convert.
REQ-005 IN_READY  output  1  block can accept a word; high only in IDLE.
REQ-006 DQ0  input  11  float word {DQS, DQEXP[3:0], DQMANT[5:0]}; DQS=1 means negative.
REQ-007 OUT_VALID  output  1  DQ and FMT_ERR hold a completed result.
REQ-008 OUT_READY  input  1  consumer accepts the result.
REQ-009 DQ  output  16  sign-magnitude linear result {sign, MAG[14:0]}.
REQ-010 FMT_ERR  output  1  the result came from a non-normalized input (DQMANT[5]=0 with DQEXP!=0).

Function
REQ-011 Conversion SHALL be MAG = (DQMANT << DQEXP) >> 6, truncated, with DQ[15]=DQS passed through unchanged, including when MAG=0.
REQ-012 The datapath SHALL use an accumulator of at least 21 bits, so no bit is lost before the final >>6; MAG SHALL always fit 15 bits (max 63<<15>>6 = 0x7E00).
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE, plus a 4-bit shift counter.
REQ-014 IDLE: IN_READY=1; on an edge with IN_VALID=1, load acc=DQMANT, cnt=DQEXP, sign=DQS and err flag, then go to SHIFT; otherwise stay.
REQ-015 SHIFT: if cnt!=0, acc<<=1 and cnt-=1 (one bit per cycle); if cnt==0, register DQ={sign, acc[20:6]} and FMT_ERR, then go to DONE.
REQ-016 DONE: OUT_VALID=1; DQ and FMT_ERR SHALL hold stable until an edge with OUT_READY=1, which returns the FSM to IDLE.
REQ-017 Latency SHALL be DQEXP+1 rising edges from the accepting edge to OUT_VALID high (1 edge for DQEXP=0, 16 edges for DQEXP=15).
REQ-018 IN_VALID outside IDLE SHALL be ignored: no queuing, and no corruption of the conversion in flight.
REQ-019 OUT_READY outside DONE SHALL be ignored.
REQ-020 Throughput SHALL be one word per DQEXP+3 cycles with OUT_READY held high; back-to-back acceptance is not supported.
REQ-021 DQEXP=0 with DQMANT=0x20 (the encoding of zero) SHALL yield MAG=0 and FMT_ERR=0.
REQ-022 DQ and FMT_ERR SHALL change only on the transition from SHIFT to DONE or on reset.

Reset
REQ-023 RESET_N low SHALL immediately force: state=IDLE, acc=0, cnt=0, DQ=0x0000, OUT_VALID=0, FMT_ERR=0, IN_READY=1, regardless of the clock.
REQ-024 A reset asserted in SHIFT or DONE SHALL discard the word in flight, with no result produced.
REQ-025 The first edge after RESET_N rises SHALL be able to accept a word.

Verification
REQ-026 DQ0=0x020 (S0 E0 M32), OUT_READY=1 -> OUT_VALID after 1 edge, DQ=0x0000, FMT_ERR=0.
REQ-027 DQ0=0x7FF (S1 E15 M63) -> OUT_VALID after 16 edges, DQ=0xFE00, FMT_ERR=0.
REQ-028 DQ0=0x1E8 (S0 E7 M40) -> OUT_VALID after 8 edges, DQ=0x0050.
REQ-029 DQ0=0x0D0 (S0 E3 M16) -> DQ=0x0002, FMT_ERR=1.
REQ-030 Result ready, OUT_READY low for 5 cycles, IN_VALID pulsed with 0x7FF -> OUT_VALID, DQ and FMT_ERR held, IN_READY=0, new word ignored; OUT_READY high -> IDLE next edge.
REQ-031 RESET_N pulsed low mid-SHIFT of 0x7FF -> all outputs at reset values at once, IN_READY=1, no OUT_VALID; the next word 0x1E8 gives DQ=0x0050.
